// File: rtl/aximm_cmd_scheduler.sv
// Round-robin scheduler sharing one AXI-MM leader among NUM_REQ requesters.
// One command in flight; completion observed on the leader's B/R taps.
module aximm_cmd_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int ADDRWIDTH   = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_wr,
   input  logic [NUM_REQ*ADDRWIDTH-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]         req_len,
   output logic                         axi_wr,
   output logic                         axi_rd,
   output logic [ADDRWIDTH-1:0]         axi_rw_addr,
   output logic [7:0]                   axi_rw_length,
   output logic [1:0]                   axi_rw_burst,
   output logic [2:0]                   axi_rw_size,
   input  logic                         obs_bvalid,
   input  logic                         obs_bready,
   input  logic [1:0]                   obs_bresp,
   input  logic                         obs_rvalid,
   input  logic                         obs_rready,
   input  logic                         obs_rlast,
   input  logic [1:0]                   obs_rresp,
   output logic                         cpl_valid,
   output logic [2:0]                   cpl_id,
   output logic [1:0]                   cpl_code,
   output logic                         busy
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [1:0] CODE_OK   = 2'b00;
   localparam logic [1:0] CODE_RESP = 2'b01;
   localparam logic [1:0] CODE_LEN  = 2'b10;
   localparam logic [1:0] CODE_TMO  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT_WR = 3'd2,
      S_WAIT_RD = 3'd3,
      S_CPL     = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [2:0]             rr_q, rr_d, gnt_q, gnt_d;
   logic                   wr_q, wr_d, err_q, err_d;
   logic [ADDRWIDTH-1:0]   addr_q, addr_d;
   logic [7:0]             len_q, len_d;
   logic [8:0]             beat_q, beat_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic                   axi_wr_q, axi_wr_d, axi_rd_q, axi_rd_d;
   logic                   cpl_valid_q, cpl_valid_d, busy_q, busy_d;
   logic [2:0]             cpl_id_q, cpl_id_d;
   logic [1:0]             cpl_code_q, cpl_code_d;

   logic [ADDRWIDTH-1:0]   addr_arr_s [8];
   logic [7:0]             len_arr_s  [8];
   logic [7:0]             valid_ext_s, wr_ext_s, onehot_s;
   logic [3:0]             arb_sum_s;
   logic                   gnt_found_s, b_hs_s, r_hs_s;
   logic [2:0]             gnt_idx_s;

   // Unused slots beyond NUM_REQ are padded so a 3-bit index is always legal.
   for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_used
         assign addr_arr_s[gi] = req_addr[gi*ADDRWIDTH +: ADDRWIDTH];
         assign len_arr_s[gi]  = req_len[gi*8 +: 8];
      end else begin : g_pad
         assign addr_arr_s[gi] = '0;
         assign len_arr_s[gi]  = 8'd0;
      end
   end

   assign valid_ext_s = 8'(req_valid);
   assign wr_ext_s    = 8'(req_wr);
   assign b_hs_s      = obs_bvalid & obs_bready;
   assign r_hs_s      = obs_rvalid & obs_rready;

   // Round-robin search starting at rr_q and wrapping.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = 3'd0;
      arb_sum_s   = 4'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_sum_s = {1'b0, rr_q} + 4'(k);
         if (arb_sum_s >= 4'(NUM_REQ)) begin
            arb_sum_s = arb_sum_s - 4'(NUM_REQ);
         end else begin
            arb_sum_s = arb_sum_s;
         end
         if (!gnt_found_s && valid_ext_s[arb_sum_s[2:0]]) begin
            gnt_found_s = 1'b1;
            gnt_idx_s   = arb_sum_s[2:0];
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_q        <= 3'd0;
         gnt_q       <= 3'd0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         len_q       <= 8'd0;
         beat_q      <= 9'd0;
         tmo_q       <= '0;
         axi_wr_q    <= 1'b0;
         axi_rd_q    <= 1'b0;
         cpl_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         cpl_id_q    <= 3'd0;
         cpl_code_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         gnt_q       <= gnt_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         tmo_q       <= tmo_d;
         axi_wr_q    <= axi_wr_d;
         axi_rd_q    <= axi_rd_d;
         cpl_valid_q <= cpl_valid_d;
         busy_q      <= busy_d;
         cpl_id_q    <= cpl_id_d;
         cpl_code_q  <= cpl_code_d;
      end
   end

   // Next-state logic; completion wins over timeout in the same cycle.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      gnt_d      = gnt_q;
      wr_d       = wr_q;
      err_d      = err_q;
      addr_d     = addr_q;
      len_d      = len_q;
      beat_d     = beat_q;
      tmo_d      = tmo_q;
      cpl_id_d   = cpl_id_q;
      cpl_code_d = cpl_code_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_found_s) begin
               gnt_d  = gnt_idx_s;
               wr_d   = wr_ext_s[gnt_idx_s];
               addr_d = addr_arr_s[gnt_idx_s];
               len_d  = len_arr_s[gnt_idx_s];
               if (len_arr_s[gnt_idx_s] == 8'd0) begin
                  state_d    = S_CPL;
                  cpl_id_d   = gnt_idx_s;
                  cpl_code_d = CODE_LEN;
               end else begin
                  state_d = S_ISSUE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            tmo_d   = '0;
            beat_d  = 9'd0;
            err_d   = 1'b0;
            state_d = wr_q ? S_WAIT_WR : S_WAIT_RD;
         end
         S_WAIT_WR: begin
            if (b_hs_s) begin
               state_d    = S_CPL;
               cpl_id_d   = gnt_q;
               cpl_code_d = (obs_bresp != 2'b00) ? CODE_RESP : CODE_OK;
            end else if (tmo_q == TMO_LAST) begin
               state_d    = S_CPL;
               cpl_id_d   = gnt_q;
               cpl_code_d = CODE_TMO;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WAIT_RD: begin
            if (r_hs_s) begin
               beat_d = beat_q + 9'd1;
               err_d  = err_q | (obs_rresp != 2'b00);
            end else begin
               beat_d = beat_q;
            end
            if (r_hs_s && obs_rlast) begin
               state_d  = S_CPL;
               cpl_id_d = gnt_q;
               if (err_q || (obs_rresp != 2'b00)) begin
                  cpl_code_d = CODE_RESP;
               end else if ((beat_q + 9'd1) != {1'b0, len_q}) begin
                  cpl_code_d = CODE_LEN;
               end else begin
                  cpl_code_d = CODE_OK;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d    = S_CPL;
               cpl_id_d   = gnt_q;
               cpl_code_d = CODE_TMO;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_CPL: begin
            rr_d    = (gnt_q == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_q + 3'd1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode: combinational accept, next values of registered outputs.
   always_comb begin
      onehot_s = 8'd1 << gnt_idx_s;
      if (rst_n && (state_q == S_IDLE) && gnt_found_s) begin
         req_ready = onehot_s[NUM_REQ-1:0];
      end else begin
         req_ready = '0;
      end
      axi_wr_d    = (state_d == S_ISSUE) && wr_d;
      axi_rd_d    = (state_d == S_ISSUE) && !wr_d;
      cpl_valid_d = (state_d == S_CPL);
      busy_d      = (state_d != S_IDLE);
   end

   assign axi_wr        = axi_wr_q;
   assign axi_rd        = axi_rd_q;
   assign axi_rw_addr   = addr_q;
   assign axi_rw_length = len_q;
   assign axi_rw_burst  = 2'b01;
   assign axi_rw_size   = 3'd4;
   assign cpl_valid     = cpl_valid_q;
   assign cpl_id        = cpl_id_q;
   assign cpl_code      = cpl_code_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_aximm_cmd_scheduler.sv
// Scoreboard bench: stimulus predicts issue and completion records from the
// round-robin/timeout rules; a negedge monitor pops and compares them.
module tb_aximm_cmd_scheduler;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int T  = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0, req_ready, req_wr = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*8-1:0]  req_len = '0;
   logic            axi_wr, axi_rd;
   logic [AW-1:0]   axi_rw_addr;
   logic [7:0]      axi_rw_length;
   logic [1:0]      axi_rw_burst;
   logic [2:0]      axi_rw_size;
   logic            obs_bvalid = 1'b0, obs_bready = 1'b0, obs_rvalid = 1'b0;
   logic            obs_rready = 1'b0, obs_rlast = 1'b0;
   logic [1:0]      obs_bresp = 2'b00, obs_rresp = 2'b00;
   logic            cpl_valid, busy;
   logic [2:0]      cpl_id;
   logic [1:0]      cpl_code;

   aximm_cmd_scheduler #(.NUM_REQ(N), .ADDRWIDTH(AW), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_len(req_len),
      .axi_wr(axi_wr), .axi_rd(axi_rd), .axi_rw_addr(axi_rw_addr),
      .axi_rw_length(axi_rw_length), .axi_rw_burst(axi_rw_burst), .axi_rw_size(axi_rw_size),
      .obs_bvalid(obs_bvalid), .obs_bready(obs_bready), .obs_bresp(obs_bresp),
      .obs_rvalid(obs_rvalid), .obs_rready(obs_rready), .obs_rlast(obs_rlast),
      .obs_rresp(obs_rresp),
      .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_code(cpl_code), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic wr; logic [AW-1:0] addr; logic [7:0] len; int cyc; } iss_t;
   typedef struct { int id; logic [1:0] code; int cyc; } cpl_t;
   iss_t iss_q[$];
   cpl_t cpl_q[$];
   iss_t ie;
   cpl_t ce;

   int checks = 0, errors = 0;
   int rr_m = 0;
   int prev_e = -1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every issue pulse and completion must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (axi_wr || axi_rd) begin
            if (iss_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_issue: got wr=%0b rd=%0b expected no pulse (cycle %0d)", axi_wr, axi_rd, cyc);
            end else begin
               ie = iss_q.pop_front();
               chk("issue_wr", 64'(axi_wr), 64'(ie.wr));
               chk("issue_rd", 64'(axi_rd), 64'(!ie.wr));
               chk("issue_addr", 64'(axi_rw_addr), 64'(ie.addr));
               chk("issue_len", 64'(axi_rw_length), 64'(ie.len));
               chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
               chk("burst_size", {59'd0, axi_rw_burst, axi_rw_size}, {59'd0, 2'b01, 3'd4});
            end
         end
         if (cpl_valid) begin
            if (cpl_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cpl: got id=%0d code=%0d expected none (cycle %0d)", cpl_id, cpl_code, cyc);
            end else begin
               ce = cpl_q.pop_front();
               chk("cpl_id", 64'(cpl_id), 64'(ce.id));
               chk("cpl_code", 64'(cpl_code), 64'(ce.code));
               chk("cpl_cycle", 64'(cyc), 64'(ce.cyc));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
      obs_bvalid = 1'b0; obs_bready = 1'b0; obs_bresp = 2'b00;
      obs_rvalid = 1'b0; obs_rready = 1'b0; obs_rlast = 1'b0; obs_rresp = 2'b00;
   endtask

   task automatic push_cpl(input int id, input logic [1:0] code, input int c);
      cpl_t t;
      t.id = id; t.code = code; t.cyc = c;
      cpl_q.push_back(t);
   endtask

   // One command: present requests, predict grant and outcome, act as the leader.
   task automatic do_txn(input logic [N-1:0] mask, input int f_wr, input int f_len,
                         input bit tmo, input int wdelay, input logic [1:0] bresp,
                         input int nb, input int errbeat);
      logic          cw [N];
      logic [AW-1:0] ca [N];
      logic [7:0]    cl [N];
      int g, a, e, beat;
      bit got, done;
      logic [1:0] code;
      iss_t it;
      g = -1;
      for (int i = 0; i < N; i++) begin
         cw[i] = (f_wr < 0) ? 1'($urandom_range(0, 1)) : 1'(f_wr);
         ca[i] = $urandom;
         cl[i] = (f_len < 0) ? 8'($urandom_range(1, 10)) : 8'(f_len);
         req_wr[i] = cw[i];
         req_addr[i*AW +: AW] = ca[i];
         req_len[i*8 +: 8] = cl[i];
      end
      for (int k = 0; k < N; k++) begin
         if (g < 0 && mask[(rr_m + k) % N]) g = (rr_m + k) % N;
      end
      req_valid = mask;
      got = 1'b0; a = 0;
      for (int k = 0; k < T + 40 && !got; k++) begin
         @(negedge clk);
         if (req_ready != '0) begin got = 1'b1; a = cyc; end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_wait: got no req_ready within bound, expected grant %0d", g);
         req_valid = '0;
         step();
         return;
      end
      chk("grant_onehot", 64'(req_ready), 64'(1) << g);
      if (prev_e >= 0) chk("grant_latency", 64'(a), 64'(prev_e + 1));
      step();
      req_valid = '0;
      rr_m = (g + 1) % N;
      if (cl[g] == 8'd0) begin
         push_cpl(g, 2'b10, a + 1);
         prev_e = a + 1;
         return;
      end
      it.wr = cw[g]; it.addr = ca[g]; it.len = cl[g]; it.cyc = a + 1;
      iss_q.push_back(it);
      if ($urandom_range(0, 1) == 1) begin
         obs_bvalid = 1'b1; obs_bready = 1'b1; obs_bresp = 2'b10;
         obs_rvalid = 1'b1; obs_rready = 1'b1; obs_rlast = 1'b1; obs_rresp = 2'b10;
      end
      step();
      done = 1'b0; beat = 0; code = 2'b11; e = a + 2 + T;
      for (int c = 0; c < T && !done; c++) begin
         if (cw[g]) begin
            if ($urandom_range(0, 3) == 0) begin
               obs_rvalid = 1'b1; obs_rready = 1'b1; obs_rlast = 1'b1; obs_rresp = 2'b11;
            end
            if (!tmo && c == wdelay) begin
               obs_bvalid = 1'b1; obs_bready = 1'b1; obs_bresp = bresp;
               done = 1'b1; e = cyc + 1;
               code = (bresp != 2'b00) ? 2'b01 : 2'b00;
            end else if ($urandom_range(0, 3) == 0) begin
               obs_bvalid = 1'b1; obs_bready = 1'b0; obs_bresp = 2'b10;
            end
         end else begin
            if ($urandom_range(0, 3) == 0) begin
               obs_bvalid = 1'b1; obs_bready = 1'b1; obs_bresp = 2'b11;
            end
            if (beat < nb && ($urandom_range(0, 2) != 0 || (T - c) <= (nb - beat))) begin
               beat++;
               obs_rvalid = 1'b1; obs_rready = 1'b1;
               obs_rresp = (beat == errbeat) ? 2'b10 : 2'b00;
               obs_rlast = !tmo && (beat == nb);
               if (obs_rlast) begin
                  done = 1'b1; e = cyc + 1;
                  code = (errbeat >= 1 && errbeat <= nb) ? 2'b01 :
                         ((nb != int'(cl[g])) ? 2'b10 : 2'b00);
               end
            end else if ($urandom_range(0, 2) == 0) begin
               obs_rvalid = 1'b1; obs_rready = 1'b0; obs_rlast = 1'b1; obs_rresp = 2'b10;
            end
         end
         if (done) push_cpl(g, code, e);
         step();
      end
      if (!done) push_cpl(g, 2'b11, e);
      while (cyc < e) step();
      prev_e = e;
   endtask

   initial begin
      int fl, nbr, eb, a;
      bit got;
      iss_t it;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cpl", {60'd0, cpl_valid, axi_wr, axi_rd, 1'b0}, 64'd0);
      chk("rst_addr_len", {24'd0, axi_rw_addr, axi_rw_length}, 64'd0);
      chk("rst_id_code", {59'd0, cpl_id, cpl_code}, 64'd0);
      rst_n = 1'b1;
      step();
      chk("idle_ready", 64'(req_ready), 64'd0);

      // Directed cases.
      do_txn(4'b0001, 1, 4, 1'b0, 2, 2'b00, 0, 0);
      repeat (4) do_txn(4'b1010, -1, -1, 1'b0, 3, 2'b00, 4, 0);
      do_txn(4'b0100, 0, 8, 1'b0, 0, 2'b00, 8, 0);
      do_txn(4'b0100, 0, 8, 1'b0, 0, 2'b00, 6, 0);
      do_txn(4'b0100, 0, 8, 1'b0, 0, 2'b00, 8, 3);
      do_txn(4'b0001, 1, 5, 1'b1, 0, 2'b00, 0, 0);
      do_txn(4'b0010, -1, 0, 1'b0, 0, 2'b00, 0, 0);
      do_txn(4'b1000, 1, 3, 1'b0, T - 1, 2'b00, 0, 0);
      do_txn(4'b1000, 1, 3, 1'b0, T - 1, 2'b10, 0, 0);
      do_txn(4'b0001, 0, 4, 1'b1, 0, 2'b00, 3, 0);

      // Randomized commands and leader behaviour.
      for (int n = 0; n < 40; n++) begin
         fl  = $urandom_range(0, 10);
         nbr = ($urandom_range(0, 1) == 1 && fl > 0) ? fl : $urandom_range(1, 12);
         eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nbr) : 0;
         do_txn(4'($urandom_range(1, 15)), -1, fl, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) == 0) ? T - 1 : $urandom_range(0, 8),
                2'($urandom_range(0, 3)), nbr, eb);
      end

      // Reset while a read is outstanding.
      req_wr[2] = 1'b0; req_addr[2*AW +: AW] = 32'hCAFE_0040; req_len[2*8 +: 8] = 8'd8;
      req_valid = 4'b0100;
      got = 1'b0; a = 0;
      for (int k = 0; k < T + 40 && !got; k++) begin
         @(negedge clk);
         if (req_ready != '0) begin got = 1'b1; a = cyc; end
      end
      chk("rst_txn_grant", 64'(req_ready), 64'b0100);
      it.wr = 1'b0; it.addr = 32'hCAFE_0040; it.len = 8'd8; it.cyc = a + 1;
      if (got) iss_q.push_back(it);
      step();
      req_valid = '0;
      step();
      step();
      obs_rvalid = 1'b1; obs_rready = 1'b1;
      req_valid = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_pulses", {61'd0, axi_wr, axi_rd, cpl_valid}, 64'd0);
      chk("abort_busy_ready", {59'd0, busy, req_ready}, 64'd0);
      chk("abort_addr_len", {24'd0, axi_rw_addr, axi_rw_length}, 64'd0);
      chk("abort_id_code", {59'd0, cpl_id, cpl_code}, 64'd0);
      req_valid = '0;
      repeat (2) step();
      rst_n = 1'b1;
      iss_q.delete();
      cpl_q.delete();
      rr_m = 0;
      prev_e = -1;
      step();
      do_txn(4'b1111, 1, 3, 1'b0, 1, 2'b00, 0, 0);

      repeat (5) step();
      chk("issue_queue_drained", 64'(iss_q.size()), 64'd0);
      chk("cpl_queue_drained", 64'(cpl_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
